// File: rtl/clk_bank_pkg.sv
// clk_bank_pkg: state encoding and bank geometry shared by the clock bank reader.
package clk_bank_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        SEND = 2'b10,
        DONE = 2'b11
    } state_t;
    localparam int BASE  = -12;
    localparam int NENT  = 4;
    localparam int IDX_W = 5;
endpackage

// File: rtl/clk_bank_next_idx.sv
// clk_bank_next_idx: finds the lowest enabled entry index strictly above cur_idx_i.
module clk_bank_next_idx
    import clk_bank_pkg::*;
(
    input  logic [BASE:BASE+NENT-1] mask_i,
    input  logic signed [IDX_W-1:0] cur_idx_i,
    output logic signed [IDX_W-1:0] next_idx_o,
    output logic                    has_next_o
);
    always_comb begin
        next_idx_o = cur_idx_i;
        has_next_o = 1'b0;
        // Scanning downward lets the lowest qualifying index win.
        for (int k = NENT - 1; k >= 0; k--) begin
            if (mask_i[BASE+k] && (BASE + k) > int'(cur_idx_i)) begin
                next_idx_o = IDX_W'(BASE + k);
                has_next_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/clk_bank_reader.sv
// clk_bank_reader: captures a negative-indexed data bank and mask on start, then
// streams every enabled entry, lowest index first, over valid/ready.
module clk_bank_reader #(
    parameter int DW   = 8,
    parameter int BASE = clk_bank_pkg::BASE,
    parameter int NENT = clk_bank_pkg::NENT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [NENT*DW-1:0]                    bank_i,
    input  logic [BASE:BASE+NENT-1]               mask_i,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DW-1:0]                         out_data,
    output logic signed [clk_bank_pkg::IDX_W-1:0] out_idx,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            sent_cnt
);
    import clk_bank_pkg::*;

    state_t                  state_q, state_d;
    logic [NENT*DW-1:0]      bank_q, bank_d;
    logic [BASE:BASE+NENT-1] mask_q, mask_d;
    logic signed [IDX_W-1:0] ptr_q, ptr_d, cur_idx, nxt_idx;
    logic [2:0]              cnt_q, cnt_d;
    logic                    has_nxt;
    logic [$clog2(NENT)-1:0] off;

    // LOAD searches from just below the first entry so entry BASE itself qualifies.
    assign cur_idx = (state_q == LOAD) ? IDX_W'(BASE - 1) : ptr_q;

    clk_bank_next_idx u_next (
        .mask_i     (mask_q),
        .cur_idx_i  (cur_idx),
        .next_idx_o (nxt_idx),
        .has_next_o (has_nxt)
    );

    assign off       = $clog2(NENT)'(ptr_q - IDX_W'(BASE));
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? bank_q[off*DW +: DW] : '0;
    assign out_idx   = out_valid ? ptr_q : '0;
    assign busy      = (state_q == LOAD) || (state_q == SEND);
    assign done      = (state_q == DONE);
    assign sent_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = (|mask_i) ? LOAD : DONE;
                bank_d  = bank_i;
                mask_d  = mask_i;
                cnt_d   = '0;
            end
            LOAD: begin
                ptr_d   = nxt_idx;
                state_d = SEND;
            end
            SEND: if (out_ready) begin
                cnt_d   = cnt_q + 3'd1;
                ptr_d   = has_nxt ? nxt_idx : ptr_q;
                state_d = has_nxt ? SEND : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_clk_bank_reader.sv
// tb_clk_bank_reader: directed scenarios for clk_bank_reader with hand-computed beats.
module tb_clk_bank_reader;
    logic              clk = 1'b0;
    logic              rst_n, start, out_ready, out_valid, busy, done;
    logic [31:0]       bank_i;
    logic [-12:-9]     mask_i;
    logic [7:0]        out_data;
    logic signed [4:0] out_idx;
    logic [2:0]        sent_cnt;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    clk_bank_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bank_i    (bank_i),
        .mask_i    (mask_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] b, input logic [-12:-9] m);
        bank_i = b;
        mask_i = m;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_idx, busy, done, sent_cnt} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {out_valid, out_data, out_idx, busy, done, sent_cnt});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_full_read();
        logic signed [4:0] ei;
        logic [7:0]        ed;
        out_ready = 1'b1;
        issue(32'h44332211, 4'b1111);
        checks++;
        if ({busy, out_valid, done} !== 3'b100) begin
            errors++;
            $display("FAIL full_load got %b exp 100", {busy, out_valid, done});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            ei = 5'(-12 + i);
            ed = 8'(17 * (i + 1));
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, ei, ed}) begin
                errors++;
                $display("FAIL full_beat%0d got v=%b idx=%0d data=%h exp v=1 idx=%0d data=%h", i, out_valid, out_idx, out_data, ei, ed);
            end
        end
        tick();
        checks++;
        if ({done, out_valid, sent_cnt} !== {2'b10, 3'd4}) begin
            errors++;
            $display("FAIL full_done got done=%b v=%b cnt=%0d exp done=1 v=0 cnt=4", done, out_valid, sent_cnt);
        end
        tick();
        checks++;
        if ({done, busy, sent_cnt} !== {2'b00, 3'd4}) begin
            errors++;
            $display("FAIL full_after got done=%b busy=%b cnt=%0d exp 0 0 4", done, busy, sent_cnt);
        end
    endtask

    task automatic test_sparse();
        logic [-12:-9] m;
        m      = '0;
        m[-12] = 1'b1;
        m[-10] = 1'b1;
        issue(32'hA4A3A2A1, m);
        tick();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b1, -5'sd12, 8'hA1}) begin
            errors++;
            $display("FAIL sparse_beat0 got v=%b idx=%0d data=%h exp 1 -12 a1", out_valid, out_idx, out_data);
        end
        tick();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b1, -5'sd10, 8'hA3}) begin
            errors++;
            $display("FAIL sparse_beat1 got v=%b idx=%0d data=%h exp 1 -10 a3", out_valid, out_idx, out_data);
        end
        tick();
        checks++;
        if ({done, out_valid, sent_cnt} !== {2'b10, 3'd2}) begin
            errors++;
            $display("FAIL sparse_done got done=%b v=%b cnt=%0d exp 1 0 2", done, out_valid, sent_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic signed [4:0] ei;
        logic [7:0]        ed;
        out_ready = 1'b0;
        issue(32'h44332211, 4'b1111);
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++;
            if ({out_valid, out_idx, out_data, sent_cnt} !== {1'b1, -5'sd12, 8'h11, 3'd0}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b idx=%0d data=%h cnt=%0d exp 1 -12 11 0", s, out_valid, out_idx, out_data, sent_cnt);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ei = 5'(-12 + i);
            ed = 8'(17 * (i + 1));
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, ei, ed}) begin
                errors++;
                $display("FAIL bp_beat%0d got v=%b idx=%0d data=%h exp 1 %0d %h", i, out_valid, out_idx, out_data, ei, ed);
            end
            tick();
        end
        checks++;
        if ({done, sent_cnt} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL bp_done got done=%b cnt=%0d exp 1 4", done, sent_cnt);
        end
        tick();
    endtask

    task automatic test_zero_mask();
        issue(32'hFFFFFFFF, 4'b0000);
        checks++;
        if ({done, out_valid, busy, sent_cnt} !== {3'b100, 3'd0}) begin
            errors++;
            $display("FAIL zero_done got done=%b v=%b busy=%b cnt=%0d exp 1 0 0 0", done, out_valid, busy, sent_cnt);
        end
        tick();
        checks++;
        if ({done, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL zero_after got %b exp 000", {done, out_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic signed [4:0] ei;
        logic [7:0]        ed;
        issue(32'h44332211, 4'b1111);
        tick();
        start  = 1'b1;
        bank_i = 32'hDDCCBBAA;
        mask_i = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 1'b0;
            ei = 5'(-12 + i);
            ed = 8'(17 * (i + 1));
            checks++;
            if ({out_valid, out_idx, out_data} !== {1'b1, ei, ed}) begin
                errors++;
                $display("FAIL busy_beat%0d got v=%b idx=%0d data=%h exp 1 %0d %h", i, out_valid, out_idx, out_data, ei, ed);
            end
            tick();
        end
        checks++;
        if ({done, sent_cnt} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL busy_done got done=%b cnt=%0d exp 1 4", done, sent_cnt);
        end
        tick();
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL busy_no_restart got %b exp 000", {busy, out_valid, done});
        end
    endtask

    task automatic test_reset_mid_send();
        issue(32'h44332211, 4'b1111);
        tick();
        tick();
        tick();
        checks++;
        if ({out_idx, sent_cnt} !== {-5'sd10, 3'd2}) begin
            errors++;
            $display("FAIL rst_pre got idx=%0d cnt=%0d exp -10 2", out_idx, sent_cnt);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({out_valid, busy, done, sent_cnt, out_idx, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL rst_mid got v=%b busy=%b done=%b cnt=%0d exp all 0", out_valid, busy, done, sent_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_no_done got %b exp 00", {done, busy});
        end
        issue(32'h08070605, 4'b0001);
        tick();
        checks++;
        if ({out_valid, out_idx, out_data} !== {1'b1, -5'sd9, 8'h08}) begin
            errors++;
            $display("FAIL rst_fresh_beat got v=%b idx=%0d data=%h exp 1 -9 08", out_valid, out_idx, out_data);
        end
        tick();
        checks++;
        if ({done, sent_cnt} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL rst_fresh_done got done=%b cnt=%0d exp 1 1", done, sent_cnt);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        bank_i    = '0;
        mask_i    = '0;
        test_reset();
        test_full_read();
        test_sparse();
        test_backpressure();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
